// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory types and arbiter state encoding
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side signal bundle for mem_arbiter
interface mem_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      ihit;
   word_t     iload;
   logic      dhit;
   word_t     dload;
   logic      err;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one single-port RAM with starvation bound
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
)(
   input  logic          CLK,
   input  logic          nRST,
   mem_arbiter_if.master bus
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] TO_LIM     = 8'(TIMEOUT);

   arb_state_t  state_q, state_d;
   logic        owner_q, owner_d;     // 1 = data path, 0 = fetch
   logic        wr_q, wr_d;
   word_t       addr_q, addr_d;
   word_t       store_q, store_d;
   logic [7:0]  to_cnt_q, to_cnt_d;
   logic [3:0]  starve_q, starve_d;
   logic        err_q, err_d;
   word_t       iload_q, iload_d;
   word_t       dload_q, dload_d;
   logic        grant_i, grant_d;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         store_q  <= '0;
         to_cnt_q <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
         iload_q  <= '0;
         dload_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         to_cnt_q <= to_cnt_d;
         starve_q <= starve_d;
         err_q    <= err_d;
         iload_q  <= iload_d;
         dload_q  <= dload_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      store_d  = store_q;
      to_cnt_d = to_cnt_q;
      starve_d = starve_q;
      err_d    = err_q;
      iload_d  = iload_q;
      dload_d  = dload_q;
      grant_i  = 1'b0;
      grant_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // A saturated starvation count overrides data priority.
            if (bus.iREN && starve_q == STARVE_LIM) grant_i = 1'b1;
            else if (bus.dREN || bus.dWEN)         grant_d = 1'b1;
            else if (bus.iREN)                      grant_i = 1'b1;

            if (grant_d) begin
               state_d  = XFER;
               owner_d  = 1'b1;
               wr_d     = bus.dWEN;
               addr_d   = bus.daddr;
               store_d  = bus.dstore;
               to_cnt_d = '0;
               if (!bus.iREN)                  starve_d = '0;
               else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
            end else if (grant_i) begin
               state_d  = XFER;
               owner_d  = 1'b0;
               wr_d     = 1'b0;
               addr_d   = bus.iaddr;
               store_d  = '0;
               to_cnt_d = '0;
               starve_d = '0;
            end
         end

         XFER: begin
            if (bus.ramstate == ACCESS) begin
               state_d = RESP;
               if (!owner_q)   iload_d = bus.ramload;
               else if (!wr_q) dload_d = bus.ramload;
            end else if (bus.ramstate == ERROR || to_cnt_q == TO_LIM) begin
               state_d = RESP;
               err_d   = 1'b1;
               if (owner_q) dload_d = ARB_ERR_WORD;
               else         iload_d = ARB_ERR_WORD;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end

         RESP: begin
            state_d  = IDLE;
            to_cnt_d = '0;
            err_d    = 1'b0;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.ramREN   = (state_q == XFER) && !wr_q;
   assign bus.ramWEN   = (state_q == XFER) && wr_q;
   assign bus.ramaddr  = addr_q;
   assign bus.ramstore = store_q;
   assign bus.ihit     = (state_q == RESP) && !owner_q;
   assign bus.dhit     = (state_q == RESP) && owner_q;
   assign bus.err      = (state_q == RESP) && err_q;
   assign bus.iload    = iload_q;
   assign bus.dload    = dload_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one single-port RAM between the instruction-fetch path and the data-memory path of the pipelined datapath. Captures one request per transaction, drives the RAM until it reports ACCESS, then returns a one-cycle hit pulse with load data to the winning requester. Data requests have priority over instruction fetches, bounded by a starvation limit so that fetch always makes progress. Sits between the datapath/cache side (`imemREN`/`dmemREN`/`dmemWEN`) and the RAM model.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while `iREN` is pending before a fetch is forced (range 1–15).
- `TIMEOUT`, 255: XFER cycles without ACCESS before the arbiter aborts with `err` (8-bit counter).
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset; one clock; reset is synchronous and active-low.
- `iREN` in 1: instruction read request; held until `ihit`.
- `iaddr` in 32: instruction address.
- `dREN` in 1: data read request; held until `dhit`.
- `dWEN` in 1: data write request; held until `dhit`.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `ihit` out 1: one-cycle completion pulse for fetch.
- `iload` out 32: fetched word; valid while `ihit`.
- `dhit` out 1: one-cycle completion pulse for data access.
- `dload` out 32: read word; valid while `dhit`.
- `err` out 1: one-cycle pulse, coincident with the hit, when a transaction aborted.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- States: IDLE, XFER, RESP.
- IDLE arbitration, evaluated every cycle:
  - Fetch is forced when `iREN` is high and `starve_cnt == STARVE_MAX`.
  - Otherwise data wins when `dREN | dWEN`.
  - Otherwise fetch wins when `iREN`.
  - Otherwise stay in IDLE.
- On a grant, register `owner` (I/D), `op` (read/write), the address, and the store data; go to XFER.
- `dWEN & dREN` together is treated as a write; `ramREN` stays low.
- XFER: `ramREN`/`ramWEN`, `ramaddr`, `ramstore` are driven only from the captured registers; request changes have no effect.
  - `ramstate == ACCESS`: capture `ramload` into the owner's load register; go to RESP.
  - `ramstate == ERROR`, or `to_cnt == TIMEOUT`: go to RESP, set `err`; load register = 32'hBAD1BAD1.
  - FREE/BUSY: `to_cnt++`.
- RESP: assert the owner's hit (plus `err` if set) for exactly one cycle; RAM enables low; no arbitration; next state IDLE; clear `to_cnt` and `err`.
- `starve_cnt` (4-bit) updates at grant time only:
  - Data grant with `iREN` high: `starve_cnt++`, saturating at `STARVE_MAX`.
  - Data grant with `iREN` low: `starve_cnt` cleared.
  - Instruction grant: `starve_cnt` cleared.
- Write transactions leave `dload` unchanged except on error; `dload`/`iload` hold their last value outside a hit.
- Reset (`nRST` low at an edge), including mid-XFER:
  - Next state is IDLE.
  - `ihit`, `dhit`, `err`, `ramREN`, `ramWEN` = 0.
  - `ramaddr`, `ramstore`, `iload`, `dload` = 0.
  - Counters and `owner` cleared.
  - The in-flight RAM transaction is abandoned; no hit is issued for it.

## Timing
- All outputs are registered or decoded from state/registered values; there is no combinational path from requests or `ramstate` to any output.
- Minimum latency, request seen in IDLE at cycle 0:
  - Cycle 0: request sampled in IDLE.
  - Cycle 1: XFER; RAM enables high.
  - Cycle 1: ACCESS → hit at cycle 2.
  - Each BUSY cycle adds one cycle.
- Back-to-back throughput is 3 cycles per zero-wait transaction: IDLE, XFER, RESP.
- Requesters drop or change their request in the cycle after hit. Since RESP performs no arbitration and IDLE samples one cycle later, a request held through its hit cycle is never re-granted twice.
- Timeout abort is asserted at XFER cycle `TIMEOUT+1`; hit/`err` follow one cycle later.

## Structure
- `ramstate_t` (FREE/BUSY/ACCESS/ERROR) and `word_t` come from `cpu_types_pkg`.
- Add to `cpu_types_pkg`:
  - `arb_state_t` enum {IDLE, XFER, RESP}.
  - Constant `ARB_ERR_WORD` = 32'hBAD1BAD1.
- Single module, no sub-modules. The starvation counter and timeout counter are small enough to stay inline.
- Expected size: about 150–200 lines.

## Test plan
- **Single fetch, zero wait:** `iREN=1`, `iaddr=0x40`, RAM returns ACCESS immediately with `0x8C220004` → `ramREN=1` at cycle 1; `ihit=1`, `iload=0x8C220004` at cycle 2; `dhit=0`.
- **Data vs fetch conflict:** `iREN` and `dREN` asserted together at cycle 0, RAM 2 BUSY cycles then ACCESS → data served first (`dhit` at cycle 4), then fetch granted at cycle 5.
- **Starvation:** `iREN` held high, `dWEN` re-asserted after every `dhit`, `STARVE_MAX=4` → exactly 4 `dhit` pulses, then `ihit`, then data resumes.
- **Simultaneous read and write:** `dREN=dWEN=1`, `daddr=0x100`, `dstore=0xDEADBEEF` → `ramWEN=1`, `ramREN=0`, `ramstore=0xDEADBEEF`; `dhit` pulse; `dload` unchanged.
- **Error and timeout:**
  - ERROR case: `ramstate=ERROR` in XFER → next cycle `dhit=1`, `err=1`, `dload=0xBAD1BAD1`.
  - Timeout case: `ramstate` held BUSY with `TIMEOUT=8` → `err` at XFER cycle 9+1.
- **Reset mid-XFER:** `nRST=0` for one edge while BUSY → next cycle all outputs 0 and state IDLE; no hit for the abandoned request; a re-asserted request completes normally.
